mdio_controller: RTL

MDIO_CONTROLLER -- requirements
Module: mdio_controller

---
 rtl/mdio_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mdio_controller.sv
// MDIO management-frame controller: shifts one 32-bit frame out on MDIO/MDC,
// turning the bus around and capturing 16 data bits on read frames.
// Latency: 1 + 64*HALF_PERIOD + 1 CLK from start acceptance to DONE; starts are dropped while BUSY.
//
// Ports:
//   CLK, RESET          system clock (rising edge), async active-low reset
//   MDIO_START, T_DATA  frame request and frame word {ST, OP, PHYAD, REGAD, TA, data}
//   MDIO_IN             serial data from the PHY during read frames
//   MDC, MDIO_OUT/OE    management clock, serial data (MSB first) and drive enable
//   RD_DATA, DATA_RDY   captured read data and its one-CLK valid pulse
//   BUSY, DONE          frame in progress, one-CLK end-of-frame pulse
module mdio_controller #(
  parameter int HALF_PERIOD = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  localparam logic [7:0] HALF_LAST   = 8'(HALF_PERIOD - 1);
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [4:0] LAST_BIT    = 5'd31;
  // Read frames release the bus at the TA field (bit 14) and sample data from bit 16.
  localparam logic [4:0] TA_BIT      = 5'd14;
  localparam logic [4:0] CAPT_BIT    = 5'd16;

  state_e      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic        is_rd_q, is_rd_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  half_cnt_q, half_cnt_d;
  logic        mdc_q, mdc_d;
  logic [15:0] rd_shift_q, rd_shift_d;
  logic [15:0] rd_data_q, rd_data_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shreg_q    <= '0;
      is_rd_q    <= 1'b0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      mdc_q      <= 1'b0;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
    end else begin
      shreg_q    <= shreg_d;
      is_rd_q    <= is_rd_d;
      bit_cnt_q  <= bit_cnt_d;
      half_cnt_q <= half_cnt_d;
      mdc_q      <= mdc_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    is_rd_d    = is_rd_q;
    bit_cnt_d  = bit_cnt_q;
    half_cnt_d = half_cnt_q;
    mdc_d      = mdc_q;
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (MDIO_START) begin
          state_d    = S_XFER;
          shreg_d    = T_DATA;
          is_rd_d    = (T_DATA[29:28] == OP_READ);
          bit_cnt_d  = '0;
          half_cnt_d = '0;
          mdc_d      = 1'b0;
          rd_shift_d = '0;
        end
      end

      S_XFER: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          if (!mdc_q) begin
            // End of low phase: MDC rises, PHY data is sampled on this edge.
            mdc_d = 1'b1;
            if (is_rd_q && (bit_cnt_q >= CAPT_BIT)) begin
              rd_shift_d = {rd_shift_q[14:0], MDIO_IN};
            end
          end else begin
            // End of high phase: bit complete, MDC falls and the next bit goes out.
            mdc_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = S_FINISH;
              // Publish read data only once the whole field has been captured.
              if (is_rd_q) begin
                rd_data_d = rd_shift_q;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              shreg_d   = {shreg_q[30:0], 1'b0};
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end

      S_FINISH: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode directly from flops, so they only move on CLK edges.
  assign MDC      = mdc_q;
  assign MDIO_OE  = (state_q == S_XFER) && (!is_rd_q || (bit_cnt_q < TA_BIT));
  assign MDIO_OUT = MDIO_OE & shreg_q[31];
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FINISH);
  assign DATA_RDY = DONE & is_rd_q;
  assign RD_DATA  = rd_data_q;

endmodule
